// File: rtl/event_pkg.sv
// Shared types for the event-camera pipeline.
//   HDR_BIT : bit of a stream byte that marks a frame header
//   CW      : width of the x, y and timestamp fields
//   ev_t    : one decoded DVS event {x, y, p, t}, 22 bits
//   state_e : frame assembler state
package event_pkg;

    localparam int HDR_BIT = 7;
    localparam int CW      = 7;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          p;
        logic [CW-1:0] t;
    } ev_t;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        HDR  = 2'd1,
        GX   = 2'd2,
        GY   = 2'd3
    } state_e;

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO of decoded events, shared with the serializer.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   push, din  : write request and data; accepted when not full, or when
//                a pop happens in the same cycle
//   pop        : read request; ignored when empty
//   dout       : head entry, straight from storage flops
//   full/empty : occupancy flags from the registered count
module event_fifo
    import event_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  ev_t  din,
    input  logic pop,
    output ev_t  dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    ev_t           mem_q [DEPTH];
    ev_t           mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        // A simultaneous pop frees the slot, so a full FIFO can still accept.
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/event_deserializer.sv
// Assembles 4-byte DVS event frames from a strobed byte stream and hands
// them to the event filter through a small FIFO.
//
// state | meaning
// HUNT  | waiting for a header byte; data bytes are discarded as errors
// HDR   | header seen (polarity held), waiting for x
// GX    | x held, waiting for y
// GY    | y held, waiting for timestamp; that byte completes the event
//
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   byte_in[7:0]      : stream byte, stable around the strobe
//   byte_stb          : asynchronous strobe, rising edge marks a byte
//   ev_valid/ev_ready : output handshake, pop when both high
//   ev_x, ev_y, ev_p, ev_t : FIFO head fields
//   err_cnt           : saturating framing/timeout error count
//   drop_cnt          : saturating count of events lost to a full FIFO
module event_deserializer
    import event_pkg::state_e, event_pkg::HUNT, event_pkg::HDR, event_pkg::GX,
           event_pkg::GY, event_pkg::HDR_BIT, event_pkg::CW;
#(
    parameter int TIMEOUT    = 255,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    byte_in,
    input  logic          byte_stb,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [CW-1:0] ev_x,
    output logic [CW-1:0] ev_y,
    output logic          ev_p,
    output logic [CW-1:0] ev_t,
    output logic [7:0]    err_cnt,
    output logic [7:0]    drop_cnt
);

    logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [1:0]    init_q, init_d;
    logic          arm_q, arm_d;
    state_e        state_q, state_d;
    logic          p_q, p_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [7:0]    idle_q, idle_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    drop_q, drop_d;

    logic          take, is_hdr, push_req, err_inc;
    logic          fifo_full, fifo_empty;
    event_pkg::ev_t push_data, head;

    always_comb begin
        s1_d   = byte_stb;
        s2_d   = s1_q;
        s3_d   = s2_q;
        // init_q[1] marks that s2 now holds a real pin sample rather than its
        // reset value. Edge detection is armed only once s2 has genuinely been
        // seen low, so a strobe held high through reset release is ignored.
        init_d = {init_q[0], 1'b1};
        arm_d  = arm_q | (init_q[1] & ~s2_q);
        take   = s2_q & ~s3_q & arm_q;
        is_hdr = byte_in[HDR_BIT];

        state_d  = state_q;
        p_d      = p_q;
        x_d      = x_q;
        y_d      = y_q;
        push_req = 1'b0;
        err_inc  = 1'b0;
        idle_d   = (state_q == HUNT || take) ? 8'd0 : idle_q + 8'd1;

        case (state_q)
            HUNT: begin
                if (take) begin
                    if (is_hdr) begin
                        p_d     = byte_in[HDR_BIT-1];
                        state_d = HDR;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            default: begin
                if (take && is_hdr) begin
                    // resync on an unexpected header, partial frame dropped
                    err_inc = 1'b1;
                    p_d     = byte_in[HDR_BIT-1];
                    state_d = HDR;
                end else if (take) begin
                    case (state_q)
                        HDR: begin
                            x_d     = byte_in[CW-1:0];
                            state_d = GX;
                        end
                        GX: begin
                            y_d     = byte_in[CW-1:0];
                            state_d = GY;
                        end
                        default: begin
                            push_req = 1'b1;
                            state_d  = HUNT;
                        end
                    endcase
                end else if (idle_q == 8'(TIMEOUT - 1)) begin
                    // this is the TIMEOUT-th idle cycle since the last byte
                    err_inc = 1'b1;
                    state_d = HUNT;
                end
            end
        endcase

        push_data = '{x: x_q, y: y_q, p: p_q, t: byte_in[CW-1:0]};

        err_d  = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        drop_d = (push_req && fifo_full && !(ev_ready && !fifo_empty) && drop_q != 8'hFF)
                 ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            init_q  <= 2'b00;
            arm_q   <= 1'b0;
            state_q <= HUNT;
            p_q     <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            idle_q  <= '0;
            err_q   <= '0;
            drop_q  <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            init_q  <= init_d;
            arm_q   <= arm_d;
            state_q <= state_d;
            p_q     <= p_d;
            x_q     <= x_d;
            y_q     <= y_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .din   (push_data),
        .pop   (ev_ready),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ev_valid = ~fifo_empty;
    assign ev_x     = head.x;
    assign ev_y     = head.y;
    assign ev_p     = head.p;
    assign ev_t     = head.t;
    assign err_cnt  = err_q;
    assign drop_cnt = drop_q;

endmodule
